sram_access_arbiter: RTL

//  Shares the single external SRAM port (16b data, 18b word address) between three requesters:
//  VGA frame reader (R0), UART image loader (R1), M1 colourspace/upsample decoder (R2).

---
 rtl/sram_access_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/sram_access_arbiter.sv
// Arbiter sharing one SRAM port between VGA reader (R0, fixed priority) and UART/M1 (R1/R2, round-robin).
// Optional ARB_STATS_EN macro adds grant/stall counters.
module sram_access_arbiter #(
  parameter int unsigned READ_LAT = 3,
  parameter int unsigned TURN_CYC = 1,
  parameter int unsigned ADDR_W   = 18
) (
  input  logic              Clock_50,
  input  logic              Reset,
  input  logic [2:0]        req_i,
  input  logic [2:0]        we_i,
  input  logic [ADDR_W-1:0] addr_i [3],
  input  logic [15:0]       wdata_i [3],
  input  logic [15:0]       SRAM_read_data_i,
  output logic [2:0]        gnt_o,
  output logic [2:0]        rvalid_o,
  output logic [15:0]       rdata_o,
  output logic [ADDR_W-1:0] SRAM_address_o,
  output logic [15:0]       SRAM_write_data_o,
  output logic              SRAM_we_n_o,
  output logic              busy_o
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]       grant_cnt_o [3],
  output logic [31:0]       stall_cnt_o
`endif
);

  localparam int unsigned TCNT_W   = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
  localparam logic [1:0]  TAG_NONE = 2'd3;

  typedef enum logic {S_READY, S_TURN} state_t;

  state_t              state, state_nx;
  logic [TCNT_W-1:0]   turn_cnt, turn_cnt_nx;
  logic                rr_r2, rr_r2_nx;
  logic                last_wr, last_wr_nx;
  logic                grant;
  logic [1:0]          win;
  logic                win_vld;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [15:0]         sel_data;
  logic [1:0]          push_tag;
  logic [1:0]          tag      [READ_LAT];
  logic [1:0]          shift_in [READ_LAT];

  // Winner selection: R0 first, then R1/R2 starting at the round-robin pointer
  always_comb begin
    win     = 2'd0;
    win_vld = 1'b0;
    if (req_i[0]) begin
      win     = 2'd0;
      win_vld = 1'b1;
    end else if (req_i[1] && (!rr_r2 || !req_i[2])) begin
      win     = 2'd1;
      win_vld = 1'b1;
    end else if (req_i[2]) begin
      win     = 2'd2;
      win_vld = 1'b1;
    end
  end

  always_comb begin
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    case (win)
      2'd0: begin sel_we = we_i[0]; sel_addr = addr_i[0]; sel_data = wdata_i[0]; end
      2'd1: begin sel_we = we_i[1]; sel_addr = addr_i[1]; sel_data = wdata_i[1]; end
      2'd2: begin sel_we = we_i[2]; sel_addr = addr_i[2]; sel_data = wdata_i[2]; end
      default: ;
    endcase
  end

  // Next-state and grant decision
  always_comb begin
    state_nx    = state;
    turn_cnt_nx = turn_cnt;
    rr_r2_nx    = rr_r2;
    last_wr_nx  = last_wr;
    grant       = 1'b0;
    case (state)
      S_READY: begin
        if (win_vld) begin
          if (last_wr && !sel_we && (TURN_CYC != 0)) begin
            state_nx    = S_TURN;
            turn_cnt_nx = '0;
            last_wr_nx  = 1'b0;
          end else begin
            grant      = 1'b1;
            last_wr_nx = sel_we;
            if (win != 2'd0) rr_r2_nx = (win == 2'd1);
          end
        end
      end
      S_TURN: begin
        if (turn_cnt == TCNT_W'(TURN_CYC - 1)) state_nx = S_READY;
        else turn_cnt_nx = turn_cnt + TCNT_W'(1);
      end
      default: state_nx = S_READY;
    endcase
  end

  always_ff @(posedge Clock_50 or posedge Reset) begin
    if (Reset) begin
      state    <= S_READY;
      turn_cnt <= '0;
      rr_r2    <= 1'b0;
      last_wr  <= 1'b0;
    end else begin
      state    <= state_nx;
      turn_cnt <= turn_cnt_nx;
      rr_r2    <= rr_r2_nx;
      last_wr  <= last_wr_nx;
    end
  end

  assign gnt_o    = (grant && !Reset) ? 3'(3'b001 << win) : 3'b000;
  assign push_tag = (grant && !sel_we) ? win : TAG_NONE;

  // Tag shift register; the last stage is the cycle rvalid_o is presented
  always_comb begin
    shift_in[0] = push_tag;
    for (int unsigned i = 1; i < READ_LAT; i++) shift_in[i] = tag[i-1];
  end

  always_ff @(posedge Clock_50 or posedge Reset) begin
    if (Reset) begin
      for (int unsigned i = 0; i < READ_LAT; i++) tag[i] <= TAG_NONE;
      rdata_o           <= '0;
      SRAM_address_o    <= '0;
      SRAM_write_data_o <= '0;
      SRAM_we_n_o       <= 1'b1;
    end else begin
      for (int unsigned i = 0; i < READ_LAT; i++) tag[i] <= shift_in[i];
      if (shift_in[READ_LAT-1] != TAG_NONE) rdata_o <= SRAM_read_data_i;
      SRAM_we_n_o <= !(grant && sel_we);
      if (grant) begin
        SRAM_address_o    <= sel_addr;
        SRAM_write_data_o <= sel_data;
      end
    end
  end

  always_comb begin
    rvalid_o = 3'b000;
    case (tag[READ_LAT-1])
      2'd0: rvalid_o = 3'b001;
      2'd1: rvalid_o = 3'b010;
      2'd2: rvalid_o = 3'b100;
      default: ;
    endcase
  end

  always_comb begin
    busy_o = (state == S_TURN);
    for (int unsigned i = 0; i < READ_LAT; i++) busy_o = busy_o | (tag[i] != TAG_NONE);
  end

`ifdef ARB_STATS_EN
  // Saturating activity counters
  always_ff @(posedge Clock_50 or posedge Reset) begin
    if (Reset) begin
      for (int unsigned i = 0; i < 3; i++) grant_cnt_o[i] <= '0;
      stall_cnt_o <= '0;
    end else begin
      for (int unsigned i = 0; i < 3; i++)
        if (gnt_o[i] && (grant_cnt_o[i] != 32'hFFFF_FFFF)) grant_cnt_o[i] <= grant_cnt_o[i] + 32'd1;
      if ((req_i != 3'b000) && (gnt_o == 3'b000) && (stall_cnt_o != 32'hFFFF_FFFF))
        stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule
